seq_multiply: RTL
=================

Name: seq_multiply

Overview:
- Multi-cycle 32x32->64 multiplier; the inverse-direction companion of the existing sequential non-restoring divider.
- Radix-2 Booth recoding retires one multiplier bit per cycle.
- Supports signed (two's complement) and unsigned operands.
- Uses the same start/done handshake as the divider so the execute unit sequences both identically.
- Its 64-bit product feeds the divider's 64-bit numerator port directly.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- signed_op  input  1  1 = operands two's complement; 0 = unsigned. Sampled with start.
- multiplicand  input  WIDTH  operand M, bit 0 = MSB.
- multiplier  input  WIDTH  operand Q, bit 0 = MSB.
- product  output  2*WIDTH  result, bit 0 = MSB; registered, held until next result.
- done  output  1  1 = idle/result valid; 0 = busy.

Behaviour:
- Reset (async, clock ignored):
  - phase=IDLE, count=0, all datapath registers 0.
  - product=0, done=1.
- Internal registers:
  - m: WIDTH+1, extended multiplicand.
  - acc: WIDTH+1, signed accumulator.
  - q: WIDTH+1, extended multiplier.
  - q_m1: 1 bit, Booth guard.
  - count: 8 bits.
- Extension rule at load:
  - signed_op=1: sign-extend M and Q by one bit.
  - signed_op=0: zero-extend M and Q by one bit.
  - With this rule, one Booth datapath covers both modes.
- IDLE:
  - If start=1 at a clock edge: m<=ext(M), q<=ext(Q), acc<=0, q_m1<=0, count<=WIDTH, done<=0, phase<=ITER.
  - Else hold; product and done unchanged.
- ITER, one edge per step, WIDTH+1 steps total:
  - Select on the pair {q[lsb], q_m1}:
    - 01: sum = acc + m.
    - 10: sum = acc + ~m + 1.
    - 00 or 11: sum = acc.
  - Arithmetic right shift of {sum, q, q_m1} by 1, with sign bit = sum MSB.
  - Addition is WIDTH+1 bits; carry-out is discarded (mod 2^(WIDTH+1)).
  - count <= count-1; when count==0 on this edge, phase<=RESULT.
- RESULT:
  - product <= low 2*WIDTH bits of {acc, q}.
  - done <= 1, phase <= IDLE.
- Latency:
  - start sampled at edge E0; done falls after E0.
  - Iterations occur at E1..E(WIDTH+1).
  - product valid and done=1 after E(WIDTH+2): 34 cycles for WIDTH=32.
  - Back-to-back: a new start may be sampled on the edge after done rises.
- Boundaries:
  - start while busy: ignored, no effect on the operation in flight.
  - start held high across completion: a second operation begins on the first IDLE edge, using the operands present then.
  - Operands may change after the start edge without effect.
  - Zero operand: result 0, same latency (fixed-latency block, no early termination).
  - Signed most-negative: -2^31 * -2^31 = 0x4000000000000000, exact.
  - Unsigned max: 0xFFFFFFFF^2 = 0xFFFFFFFE00000001.
  - reset mid-operation: abort immediately; product=0, done=1; no partial result ever appears on product.
  - Illegal phase encoding: next edge goes to IDLE.

Decomposition:
- Shared package holds:
  - The WIDTH constant, shared with the divider.
  - Phase encodings IDLE=0, ITER=1, RESULT=2.
  - Booth-pair select constants.
- Natural sub-module: booth_addsub.
  - Combinational, WIDTH+1 bits.
  - Inputs: acc, m, 2-bit pair. Output: sum.
  - Implemented as acc + (m or ~m or 0) + cin in a single adder, matching the divider's carry_sum structure.
  - Independently testable.

Test Plan:
- Unsigned 113*31, signed_op=0 -> product=3503 (0x0000000000000DAF); done low exactly 34 cycles after the start edge.
- Unsigned 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE00000001. Same operands with signed_op=1 -> 0x0000000000000001.
- Signed -7*3, i.e. 0xFFFFFFF9*0x00000003 with signed_op=1 -> 0xFFFFFFFFFFFFFFEB. Also 0x80000000*0x80000000 signed -> 0x4000000000000000.
- Unsigned 0xFFFFFFFF*2 -> 0x00000001FFFFFFFE. Same operands signed -> 0xFFFFFFFFFFFFFFFE.
- Busy/abort:
  - Pulse start on 1000*1000; re-assert start with 5*5 at cycle 10 -> product=1000000, ignoring the second request.
  - Restart and assert reset at cycle 15 -> product=0, done=1 immediately.
  - Next run of 12*12 -> 144.
- Round trip with the divider: random 32-bit A, B (B != 0), unsigned. Multiply, then divide the 64-bit product by B -> quotient=A, remainder=0. Repeat over 1000 random pairs.

Source files
------------

// File: rtl/seq_multiply_pkg.sv
// seq_multiply_pkg: operand width, phase encoding and Booth pair codes
// shared by the sequential multiplier and its divider companion.
package seq_multiply_pkg;
   localparam int WIDTH = 32;
   typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, RESULT = 2'd2} phase_t;
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;
endpackage

// File: rtl/seq_multiply_if.sv
// seq_multiply_if: start/done request bus shared with the divider; bit 0 of
// every vector is its MSB.
interface seq_multiply_if #(parameter int WIDTH = seq_multiply_pkg::WIDTH);
   import seq_multiply_pkg::*;
   logic start;
   logic signed_op;
   logic [0:WIDTH-1] multiplicand;
   logic [0:WIDTH-1] multiplier;
   logic [0:2*WIDTH-1] product;
   logic done;
   modport master(output start, signed_op, multiplicand, multiplier, input product, done);
   modport slave(input start, signed_op, multiplicand, multiplier, output product, done);
endinterface

// File: rtl/seq_multiply_booth_addsub.sv
// seq_multiply_booth_addsub: one Booth step's add/subtract/hold as a single
// carry-in adder, acc + (m | ~m | 0) + cin.
module seq_multiply_booth_addsub
   import seq_multiply_pkg::*;
#(parameter int N = WIDTH + 1)
(
   input  logic [N-1:0] acc,
   input  logic [N-1:0] m,
   input  logic [1:0]   pair,
   output logic [N-1:0] sum
);
   logic [N-1:0] operand;
   logic cin;
   always_comb begin
      operand = pair == BOOTH_ADD ? m : pair == BOOTH_SUB ? ~m : '0;
      cin = pair == BOOTH_SUB;
      sum = acc + operand + N'(cin);
   end
endmodule

// File: rtl/seq_multiply.sv
// seq_multiply: multi-cycle radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH,
// signed or unsigned, fixed latency of WIDTH+2 cycles from the start edge.
module seq_multiply #(parameter int WIDTH = seq_multiply_pkg::WIDTH) (
   input logic clock,
   input logic reset,
   seq_multiply_if.slave bus
);
   import seq_multiply_pkg::*;
   localparam int N = WIDTH + 1;
   phase_t phase, phase_n;
   logic [7:0] count, count_n;
   logic [N-1:0] m, m_n, acc, acc_n, q, q_n, sum;
   logic q_m1, q_m1_n;
   logic [2*WIDTH-1:0] product, product_n;
   logic done, done_n;
   logic [WIDTH-1:0] mcand, mplier;
   assign mcand = bus.multiplicand;
   assign mplier = bus.multiplier;
   assign bus.product = product;
   assign bus.done = done;
   seq_multiply_booth_addsub #(.N(N)) addsub (
      .acc(acc),
      .m(m),
      .pair({q[0], q_m1}),
      .sum(sum)
   );
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         phase <= IDLE;
         count <= '0;
         m <= '0;
         acc <= '0;
         q <= '0;
         q_m1 <= 1'b0;
         product <= '0;
         done <= 1'b1;
      end else begin
         phase <= phase_n;
         count <= count_n;
         m <= m_n;
         acc <= acc_n;
         q <= q_n;
         q_m1 <= q_m1_n;
         product <= product_n;
         done <= done_n;
      end
   end
   // The one-bit extension lets a single signed Booth datapath cover both modes.
   always_comb begin
      phase_n = phase;
      count_n = count;
      m_n = m;
      acc_n = acc;
      q_n = q;
      q_m1_n = q_m1;
      product_n = product;
      done_n = done;
      case (phase)
         IDLE: if (bus.start) begin
            m_n = {bus.signed_op & mcand[WIDTH-1], mcand};
            q_n = {bus.signed_op & mplier[WIDTH-1], mplier};
            acc_n = '0;
            q_m1_n = 1'b0;
            count_n = 8'(WIDTH);
            done_n = 1'b0;
            phase_n = ITER;
         end
         ITER: begin
            {acc_n, q_n, q_m1_n} = {sum[N-1], sum, q};
            count_n = count - 8'd1;
            phase_n = count == 8'd0 ? RESULT : ITER;
         end
         RESULT: begin
            product_n = {acc[N-3:0], q};
            done_n = 1'b1;
            phase_n = IDLE;
         end
         default: begin
            done_n = 1'b1;
            phase_n = IDLE;
         end
      endcase
   end
endmodule
